// File: rtl/virtual_source.sv
// virtual_source: injects a fixed-length stream of sequence-numbered flits into one NI ingress port.
// Optional feature macro VSRC_CREDIT_EN: credit-based flow control instead of valid/ready.
module virtual_source #(
  parameter int unsigned num_flits    = 1000,
  parameter int unsigned gap          = 0,
  parameter int unsigned x            = 0,
  parameter int unsigned y            = 0,
  parameter int unsigned credit_depth = 4,
  parameter int unsigned DW           = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
`ifdef VSRC_CREDIT_EN
  input  logic          credit_upd_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  output logic [31:0]   sent_cnt_o
);

  localparam int unsigned GW       = (gap > 1) ? $clog2(gap + 1) : 1;
  localparam logic [7:0]  X8       = 8'(x);
  localparam logic [7:0]  Y8       = 8'(y);
  localparam logic [31:0] LAST_IDX = 32'(num_flits - 1);
  localparam bit          HAS_GAP  = (gap != 0);
  localparam bit          NO_FLITS = (num_flits == 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e        state;
  logic [15:0]   seq;
  logic [GW-1:0] gap_cnt;
  logic          xfer_c;
  logic          can_send_c;

  function automatic logic [DW-1:0] flit(input logic [15:0] s);
    return DW'({X8, Y8, s});
  endfunction

`ifdef VSRC_CREDIT_EN
  localparam int unsigned    CW   = $clog2(credit_depth + 1);
  localparam logic [CW-1:0]  CMAX = CW'(credit_depth);

  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nxt_c;
  logic          unused_ready;

  assign unused_ready = ready_i;
  assign xfer_c       = valid_o;

  // Net credit change; a transfer and a return in the same cycle cancel out
  always_comb begin
    credits_nxt_c = credits;
    if (xfer_c && !credit_upd_i)
      credits_nxt_c = credits - CW'(1);
    else if (!xfer_c && credit_upd_i && (credits != CMAX))
      credits_nxt_c = credits + CW'(1);
  end

  assign can_send_c = (credits_nxt_c != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits <= CMAX;
    end else begin
      credits <= credits_nxt_c;
`ifndef SYNTHESIS
      assert (!(credit_upd_i && !xfer_c && (credits == CMAX)))
        else $error("time %0t: node (%0d, %0d) credit overflow", $time, x, y);
`endif
    end
  end
`else
  localparam int unsigned unused_credit_depth = credit_depth;

  assign xfer_c     = valid_o & ready_i;
  assign can_send_c = 1'b1;
`endif

  // Main sequencer; every output is a register so nothing from ready_i reaches valid_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      valid_o    <= 1'b0;
      data_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sent_cnt_o <= '0;
      seq        <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            sent_cnt_o <= '0;
            seq        <= '0;
            data_o     <= flit(16'd0);
            if (NO_FLITS) begin
              state   <= DONE;
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
`ifndef SYNTHESIS
              $display("time %0t: node (%0d, %0d) finished transmitting 0 flits", $time, x, y);
`endif
            end else begin
              state   <= SEND;
              valid_o <= can_send_c;
              busy_o  <= 1'b1;
              done_o  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (xfer_c) begin
            seq        <= seq + 16'd1;
            sent_cnt_o <= sent_cnt_o + 32'd1;
`ifndef SYNTHESIS
            if (sent_cnt_o == 32'd0)
              $display("time %0t: node (%0d, %0d) starting transmitting", $time, x, y);
`endif
            if (sent_cnt_o == LAST_IDX) begin
              state   <= DONE;
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
`ifndef SYNTHESIS
              $display("time %0t: node (%0d, %0d) finished transmitting %0d flits",
                       $time, x, y, num_flits);
`endif
            end else begin
              data_o <= flit(seq + 16'd1);
              if (HAS_GAP) begin
                state   <= GAP;
                valid_o <= 1'b0;
                gap_cnt <= GW'(gap);
              end else begin
                valid_o <= can_send_c;
              end
            end
          end else begin
            valid_o <= can_send_c;
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) begin
            state   <= SEND;
            valid_o <= can_send_c;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
